// File: rtl/adder_tree_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined adder tree.
package adder_tree_pkg;

  localparam int DEFAULT_ADDER_BUS_SIZE = 32;
  localparam int DEFAULT_ADDER_CHANNELS = 4;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

  // Number of registered tree levels; a single channel still gets one stage.
  function automatic int tree_levels(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Operands left after one pairwise reduction; an odd leftover passes through.
  function automatic int half_width(input int n);
    return (n + 1) / 2;
  endfunction

  // Operand count entering a given level of a tree fed with n operands.
  function automatic int level_width(input int n, input int level);
    int w;
    w = n;
    for (int i = 0; i < level; i++) w = half_width(w);
    return w;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered level of the adder tree: N_IN operands in, ceil(N_IN/2) out.
// Each output carries a sticky overflow bit. With ADDER_TREE_SATURATE_EN
// defined, any node whose overflow bit is set outputs all-ones.
module adder_tree_level
  import adder_tree_pkg::*;
#(
  parameter int  BUS_SIZE = DEFAULT_ADDER_BUS_SIZE,
  parameter int  N_IN     = DEFAULT_ADDER_CHANNELS,
  localparam int N_OUT    = half_width(N_IN)
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_stall,
  input  logic [N_IN*BUS_SIZE-1:0]  in_data,
  input  logic [N_IN-1:0]           in_ovf,
  input  logic                      in_valid,
  output logic [N_OUT*BUS_SIZE-1:0] out_data,
  output logic [N_OUT-1:0]          out_ovf,
  output logic                      out_valid
);

  logic [N_OUT*BUS_SIZE-1:0] node_data;
  logic [N_OUT-1:0]          node_ovf;

  for (genvar j = 0; j < N_OUT; j++) begin : g_node
    logic [BUS_SIZE-1:0] sum_val;
    logic                ovf;

    if (2 * j + 1 < N_IN) begin : g_add
      // One extra bit captures the carry-out of this node's addition.
      logic [BUS_SIZE:0] wide;
      assign wide    = {1'b0, in_data[(2*j)*BUS_SIZE +: BUS_SIZE]}
                     + {1'b0, in_data[(2*j+1)*BUS_SIZE +: BUS_SIZE]};
      assign sum_val = wide[BUS_SIZE-1:0];
      assign ovf     = in_ovf[2*j] | in_ovf[2*j+1] | wide[BUS_SIZE];
    end else begin : g_pass
      // Odd leftover operand: forwarded unchanged along with its overflow bit.
      assign sum_val = in_data[(2*j)*BUS_SIZE +: BUS_SIZE];
      assign ovf     = in_ovf[2*j];
    end

`ifdef ADDER_TREE_SATURATE_EN
    assign node_data[j*BUS_SIZE +: BUS_SIZE] = ovf ? {BUS_SIZE{1'b1}} : sum_val;
`else
    assign node_data[j*BUS_SIZE +: BUS_SIZE] = sum_val;
`endif
    assign node_ovf[j] = ovf;
  end

  // Stage register: reset clears everything, stall freezes everything.
  always_ff @(posedge i_clk) begin
    // NOTE: state is written with <= so every stage samples the pre-edge value
    // of its upstream stage; blocking writes would let a sample race ahead.
    if (i_reset) begin
      // NOTE: the data registers are reset too (not just valid), because the
      // result output must read zero on the cycle after reset.
      out_data  <= '0;
      out_ovf   <= '0;
      out_valid <= 1'b0;
    end else if (!i_stall) begin
      out_data  <= node_data;
      out_ovf   <= node_ovf;
      out_valid <= in_valid;
    end
  end

endmodule

// File: rtl/adder_tree_pipelined.sv
// Pipelined multi-channel unsigned adder: CHANNELS operands of BUS_SIZE bits
// reduced through a registered binary tree, one register per level, with
// valid tracking, whole-pipeline stall and sticky per-sample overflow.
// Optional build macro: ADDER_TREE_SATURATE_EN (saturate to all-ones on
// overflow instead of wrapping modulo 2^BUS_SIZE).
module adder_tree_pipelined
  import adder_tree_pkg::*;
#(
  parameter int BUS_SIZE = DEFAULT_ADDER_BUS_SIZE,
  parameter int CHANNELS = DEFAULT_ADDER_CHANNELS
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [CHANNELS*BUS_SIZE-1:0] i_values,
  input  logic                         i_valid,
  input  logic                         i_stall,
  output logic [BUS_SIZE-1:0]          o_result,
  output logic                         o_valid,
  output logic                         o_overflow
);

  localparam int LEVELS = tree_levels(CHANNELS);

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int N_IN  = level_width(CHANNELS, l);
    localparam int N_OUT = half_width(N_IN);

    logic [N_IN*BUS_SIZE-1:0]  lvl_in_data;
    logic [N_IN-1:0]           lvl_in_ovf;
    logic                      lvl_in_valid;
    logic [N_OUT*BUS_SIZE-1:0] lvl_out_data;
    logic [N_OUT-1:0]          lvl_out_ovf;
    logic                      lvl_out_valid;

    if (l == 0) begin : g_src
      // Raw operands enter with no overflow history.
      assign lvl_in_data  = i_values;
      assign lvl_in_ovf   = '0;
      assign lvl_in_valid = i_valid;
    end else begin : g_chain
      assign lvl_in_data  = g_lvl[l-1].lvl_out_data;
      assign lvl_in_ovf   = g_lvl[l-1].lvl_out_ovf;
      assign lvl_in_valid = g_lvl[l-1].lvl_out_valid;
    end

    adder_tree_level #(
      .BUS_SIZE (BUS_SIZE),
      .N_IN     (N_IN)
    ) u_level (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_stall   (i_stall),
      .in_data   (lvl_in_data),
      .in_ovf    (lvl_in_ovf),
      .in_valid  (lvl_in_valid),
      .out_data  (lvl_out_data),
      .out_ovf   (lvl_out_ovf),
      .out_valid (lvl_out_valid)
    );
  end

  // The last level always reduces to exactly one operand.
  assign o_result   = g_lvl[LEVELS-1].lvl_out_data;
  assign o_overflow = g_lvl[LEVELS-1].lvl_out_ovf[0];
  assign o_valid    = g_lvl[LEVELS-1].lvl_out_valid;

endmodule

// File: tb/tb_adder_tree_pipelined.sv
// Self-checking bench for adder_tree_pipelined. Three instances with 8-bit
// operands (4, 5 and 1 channels) share clock, reset and stall. A reference
// model computes each sample's true sum with plain integer arithmetic and
// schedules it by counting non-stalled edges; directed tables and sequences
// cover the listed corner cases, then a randomized phase runs all three.
module tb_adder_tree_pipelined;

`ifdef ADDER_TREE_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam int NDUT = 3;
  localparam int NCH [NDUT] = '{4, 5, 1};
  localparam int LAT [NDUT] = '{2, 3, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       stall;
  logic [7:0] vals  [NDUT][5];
  logic       valid [NDUT];

  logic [31:0] pv4;
  logic [39:0] pv5;
  logic [7:0]  pv1;
  always_comb begin
    pv4 = {vals[0][3], vals[0][2], vals[0][1], vals[0][0]};
    pv5 = {vals[1][4], vals[1][3], vals[1][2], vals[1][1], vals[1][0]};
    pv1 = vals[2][0];
  end

  logic [7:0] r4, r5, r1;
  logic       v4, v5, v1, o4, o5, o1;

  adder_tree_pipelined #(.BUS_SIZE(8), .CHANNELS(4)) dut4 (
    .i_clk(clk), .i_reset(reset), .i_values(pv4), .i_valid(valid[0]),
    .i_stall(stall), .o_result(r4), .o_valid(v4), .o_overflow(o4));
  adder_tree_pipelined #(.BUS_SIZE(8), .CHANNELS(5)) dut5 (
    .i_clk(clk), .i_reset(reset), .i_values(pv5), .i_valid(valid[1]),
    .i_stall(stall), .o_result(r5), .o_valid(v5), .o_overflow(o5));
  adder_tree_pipelined #(.BUS_SIZE(8), .CHANNELS(1)) dut1 (
    .i_clk(clk), .i_reset(reset), .i_values(pv1), .i_valid(valid[2]),
    .i_stall(stall), .o_result(r1), .o_valid(v1), .o_overflow(o1));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] res;
    bit         ovf;
    int         due;   // non-stalled edge count at which it must appear
  } exp_t;

  exp_t       pend [NDUT][$];
  int         edges [NDUT];
  bit         ev [NDUT];
  logic [7:0] er [NDUT];
  bit         eo [NDUT];
  bit         ezero [NDUT];
  bit         last_stall, last_reset;
  logic [7:0] got4 [$];

  function automatic exp_t ref_sample(input int d, input int due);
    exp_t e;
    int   total;
    total = 0;
    for (int k = 0; k < NCH[d]; k++) total += int'(vals[d][k]);
    e.ovf = (total > 255);
    e.res = (SAT && e.ovf) ? 8'hFF : total[7:0];
    e.due = due;
    return e;
  endfunction

  // One clock: update the model at the edge, compare on the falling edge.
  task automatic tick();
    logic [7:0] ar [NDUT];
    logic       av [NDUT];
    logic       ao [NDUT];
    @(posedge clk);
    for (int d = 0; d < NDUT; d++) begin
      if (reset) begin
        pend[d].delete();
        ev[d]    = 1'b0;
        ezero[d] = 1'b1;
      end else if (!stall) begin
        ezero[d] = 1'b0;
        edges[d]++;
        if (valid[d]) pend[d].push_back(ref_sample(d, edges[d] + LAT[d] - 1));
        ev[d] = 1'b0;
        if (pend[d].size() > 0 && pend[d][0].due == edges[d]) begin
          ev[d] = 1'b1;
          er[d] = pend[d][0].res;
          eo[d] = pend[d][0].ovf;
          void'(pend[d].pop_front());
        end
      end
    end
    last_stall = stall;
    last_reset = reset;
    @(negedge clk);
    ar = '{r4, r5, r1};
    av = '{v4, v5, v1};
    ao = '{o4, o5, o1};
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("valid[ch%0d]", NCH[d]), int'(av[d]), int'(ev[d]));
      if (ev[d] || ezero[d]) begin
        check($sformatf("result[ch%0d]", NCH[d]), int'(ar[d]), ezero[d] ? 0 : int'(er[d]));
        check($sformatf("overflow[ch%0d]", NCH[d]), int'(ao[d]), ezero[d] ? 0 : int'(eo[d]));
      end
    end
    if (!last_stall && !last_reset && v4) got4.push_back(r4);
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < NDUT; d++) begin
      valid[d] = 1'b0;
      for (int k = 0; k < 5; k++) vals[d][k] = 8'd0;
    end
  endtask

  // ---------------- directed table for the 4-channel instance ----------------
  typedef struct {
    logic [7:0] v [4];
    logic [7:0] res;
    bit         ovf;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{'{8'd1,   8'd2,   8'd3,   8'd4  }, 8'd10,                    1'b0};
    tbl[1] = '{'{8'd200, 8'd100, 8'd0,   8'd0  }, SAT ? 8'd255 : 8'd44,     1'b1};
    tbl[2] = '{'{8'd255, 8'd1,   8'd0,   8'd0  }, SAT ? 8'd255 : 8'd0,      1'b1};
    tbl[3] = '{'{8'd255, 8'd255, 8'd255, 8'd255}, SAT ? 8'd255 : 8'd252,    1'b1};
    tbl[4] = '{'{8'd100, 8'd50,  8'd60,  8'd45 }, 8'd255,                   1'b0};
    tbl[5] = '{'{8'd0,   8'd0,   8'd128, 8'd128}, SAT ? 8'd255 : 8'd0,      1'b1};

    for (int d = 0; d < NDUT; d++) begin
      edges[d] = 0; ev[d] = 1'b0; er[d] = '0; eo[d] = 1'b0; ezero[d] = 1'b0;
    end
    last_stall = 1'b0;
    last_reset = 1'b0;
    idle_inputs();
    stall = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Table: one sample each, result exactly 2 cycles later for one cycle.
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 4; k++) vals[0][k] = tbl[i].v[k];
      valid[0] = 1'b1;
      tick();
      valid[0] = 1'b0;
      check($sformatf("tbl%0d early valid", i), int'(v4), 0);
      tick();
      check($sformatf("tbl%0d valid", i), int'(v4), 1);
      check($sformatf("tbl%0d result", i), int'(r4), int'(tbl[i].res));
      check($sformatf("tbl%0d overflow", i), int'(o4), int'(tbl[i].ovf));
      tick();
      check($sformatf("tbl%0d valid one cycle", i), int'(v4), 0);
    end

    // Odd channel count: latency 3, 1+1+1+1+250 = 254, no overflow.
    vals[1] = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd250};
    valid[1] = 1'b1;
    tick();
    valid[1] = 1'b0;
    tick();
    check("odd early valid", int'(v5), 0);
    tick();
    check("odd valid", int'(v5), 1);
    check("odd result", int'(r5), 254);
    check("odd overflow", int'(o5), 0);
    tick();

    // Single channel: 0xA5 appears after one cycle, never overflows.
    vals[2][0] = 8'hA5;
    valid[2] = 1'b1;
    tick();
    valid[2] = 1'b0;
    check("single valid", int'(v1), 1);
    check("single result", int'(r1), 'hA5);
    check("single overflow", int'(o1), 0);
    tick();

    // Reset mid-flight: in-flight samples and a sample presented with reset vanish.
    idle_inputs();
    for (int s = 0; s < 2; s++) begin
      for (int d = 0; d < NDUT; d++) begin
        valid[d] = 1'b1;
        vals[d][0] = 8'(s + 7);
      end
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    check("post-reset valid", int'(v4), 0);
    check("post-reset result", int'(r4), 0);
    check("post-reset overflow", int'(o4), 0);
    for (int c = 0; c < 5; c++) tick();

    // Streaming with a 3-cycle stall: sums 0..5 emerge once each, in order.
    got4.delete();
    for (int k = 0; k < 6; k++) begin
      if (k == 3) begin
        stall = 1'b1;
        vals[0][0] = 8'd99;   // ignored while stalled
        valid[0] = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        stall = 1'b0;
      end
      vals[0][0] = 8'(k);
      valid[0] = 1'b1;
      tick();
    end
    idle_inputs();
    for (int c = 0; c < 4; c++) tick();
    check("stream count", got4.size(), 6);
    for (int k = 0; k < 6 && k < got4.size(); k++)
      check($sformatf("stream order %0d", k), int'(got4[k]), k);

    // Randomized traffic on all instances, with occasional stall and reset.
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < NDUT; d++) begin
        valid[d] = ($urandom_range(0, 9) < 7);
        for (int k = 0; k < 5; k++)
          vals[d][k] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                   : 8'($urandom_range(0, 40));
      end
      stall = ($urandom_range(0, 9) < 2);
      reset = ($urandom_range(0, 99) < 2);
      tick();
    end
    reset = 1'b0;
    stall = 1'b0;
    idle_inputs();
    for (int c = 0; c < 5; c++) tick();
    for (int d = 0; d < NDUT; d++)
      check($sformatf("drained[ch%0d]", NCH[d]), pend[d].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
